ucode_fetch: RTL and testbench

- Microinstruction fetch controller directly upstream of the instruction register.
- Takes the next micro-PC, reads the 49-bit microinstruction from external control memory over a req/ack port, and holds it stable on `i` for the IR load at `state_fetch`.
- Arbitrates microcode writes (IWRITE path) against reads.
- Checks odd parity.
- Keeps a one-entry last-address hit register so straight re-fetches skip the memory round trip.

---
 rtl/ucode_pkg.sv | 19 +
 rtl/ucode_par_chk.sv | 13 +
 rtl/ucode_fetch.sv | 181 ++++++++++++++++++
 tb/tb_ucode_fetch.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// Shared types and helpers for the microinstruction fetch controller.
package ucode_pkg;

  localparam int UCODE_W = 49;
  localparam int UADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  // Odd parity holds when the XOR over the whole word is 1. Zero-extension
  // does not change the XOR, so any word up to 64 bits can be passed in.
  function automatic logic odd_parity_ok(input logic [63:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/ucode_par_chk.sv
// Combinational odd-parity reducer for a fetched microinstruction.
module ucode_par_chk
  import ucode_pkg::*;
#(
  parameter int W = UCODE_W
) (
  input  logic [W-1:0] data,
  output logic         ok
);

  assign ok = odd_parity_ok(64'(data));

endmodule

// File: rtl/ucode_fetch.sv
// Microinstruction fetch controller: reads control memory over a req/ack
// port, arbitrates microcode writes against reads, checks odd parity and
// keeps a one-entry last-address hit register to skip repeated fetches.
module ucode_fetch
  import ucode_pkg::*;
#(
  parameter int ADDR_W    = UADDR_W,
  parameter int DATA_W    = UCODE_W,
  parameter bit PAR_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              iwrite,
  input  logic [ADDR_W-1:0] iwrite_addr,
  input  logic [DATA_W-1:0] iwrite_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] i,
  output logic              i_valid,
  output logic              busy,
  output logic              par_err
);

  state_t              state, state_nxt;
  logic                rd_pend, rd_pend_nxt;
  logic [ADDR_W-1:0]   rd_pend_addr, rd_pend_addr_nxt;
  logic                wr_pend, wr_pend_nxt;
  logic [ADDR_W-1:0]   wr_pend_addr, wr_pend_addr_nxt;
  logic [DATA_W-1:0]   wr_pend_data, wr_pend_data_nxt;
  logic                hit_vld, hit_vld_nxt;
  logic [ADDR_W-1:0]   hit_addr, hit_addr_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt, i_nxt;
  logic                i_valid_nxt, par_err_nxt;
  logic                par_ok;
  logic                dispatch;

  // A request arriving in the same cycle as the slot it would fill wins
  // over the older pending one (last request of a kind wins).
  logic                eff_wr, eff_rd;
  logic [ADDR_W-1:0]   eff_waddr, eff_raddr;
  logic [DATA_W-1:0]   eff_wdata;

  assign eff_wr    = iwrite | wr_pend;
  assign eff_waddr = iwrite ? iwrite_addr : wr_pend_addr;
  assign eff_wdata = iwrite ? iwrite_data : wr_pend_data;
  assign eff_rd    = fetch_req | rd_pend;
  assign eff_raddr = fetch_req ? pc : rd_pend_addr;

  generate
    if (PAR_CHECK) begin : g_par
      ucode_par_chk #(.W(DATA_W)) u_par (.data(mem_rdata), .ok(par_ok));
    end else begin : g_nopar
      assign par_ok = 1'b1;
    end
  endgenerate

  assign mem_rd = (state == RD_WAIT);
  assign mem_wr = (state == WR_WAIT);
  assign busy   = (state != IDLE) | rd_pend | wr_pend;

  // Next-state logic: complete the current memory op, then pick the next
  // op (write before read) in the same cycle so back-to-back ops have no gap.
  always_comb begin
    state_nxt        = state;
    rd_pend_nxt      = rd_pend;
    rd_pend_addr_nxt = rd_pend_addr;
    wr_pend_nxt      = wr_pend;
    wr_pend_addr_nxt = wr_pend_addr;
    wr_pend_data_nxt = wr_pend_data;
    hit_vld_nxt      = hit_vld;
    hit_addr_nxt     = hit_addr;
    addr_nxt         = mem_addr;
    wdata_nxt        = mem_wdata;
    i_nxt            = i;
    i_valid_nxt      = i_valid;
    par_err_nxt      = par_err;
    dispatch         = 1'b0;

    case (state)
      IDLE: dispatch = 1'b1;  // mem_ack is ignored here
      RD_WAIT: begin
        if (mem_ack) begin
          i_nxt        = mem_rdata;
          i_valid_nxt  = 1'b1;
          hit_vld_nxt  = 1'b1;
          hit_addr_nxt = mem_addr;
          if (!par_ok) par_err_nxt = 1'b1;
          dispatch     = 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          if (hit_vld && hit_addr == mem_addr) hit_vld_nxt = 1'b0;
          dispatch = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (!dispatch) begin
      // Still waiting on memory: park new requests in their slots.
      if (iwrite) begin
        wr_pend_nxt      = 1'b1;
        wr_pend_addr_nxt = iwrite_addr;
        wr_pend_data_nxt = iwrite_data;
      end
      if (fetch_req) begin
        rd_pend_nxt      = 1'b1;
        rd_pend_addr_nxt = pc;
        i_valid_nxt      = 1'b0;
      end
    end else begin
      rd_pend_nxt = 1'b0;
      wr_pend_nxt = 1'b0;
      if (eff_wr) begin
        state_nxt = WR_WAIT;
        addr_nxt  = eff_waddr;
        wdata_nxt = eff_wdata;
        if (eff_rd) begin
          // Read waits behind the write and is hit-checked again afterwards.
          rd_pend_nxt      = 1'b1;
          rd_pend_addr_nxt = eff_raddr;
          i_valid_nxt      = 1'b0;
        end
      end else if (eff_rd) begin
        // Hit check uses the hit register as updated by the op just finished.
        if (hit_vld_nxt && hit_addr_nxt == eff_raddr) begin
          state_nxt   = IDLE;
          i_valid_nxt = 1'b1;
        end else begin
          state_nxt   = RD_WAIT;
          addr_nxt    = eff_raddr;
          i_valid_nxt = 1'b0;
        end
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rd_pend      <= 1'b0;
      rd_pend_addr <= '0;
      wr_pend      <= 1'b0;
      wr_pend_addr <= '0;
      wr_pend_data <= '0;
      hit_vld      <= 1'b0;
      hit_addr     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i            <= '0;
      i_valid      <= 1'b0;
      par_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      rd_pend      <= rd_pend_nxt;
      rd_pend_addr <= rd_pend_addr_nxt;
      wr_pend      <= wr_pend_nxt;
      wr_pend_addr <= wr_pend_addr_nxt;
      wr_pend_data <= wr_pend_data_nxt;
      hit_vld      <= hit_vld_nxt;
      hit_addr     <= hit_addr_nxt;
      mem_addr     <= addr_nxt;
      mem_wdata    <= wdata_nxt;
      i            <= i_nxt;
      i_valid      <= i_valid_nxt;
      par_err      <= par_err_nxt;
    end
  end

endmodule

// File: tb/tb_ucode_fetch.sv
// Scoreboard bench for ucode_fetch: a transaction-level model predicts the
// memory ops and the final IR word; a responder/monitor checks them.
module tb_ucode_fetch;

  localparam int AW = 14;
  localparam int DW = 49;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc = '0;
  logic          fetch_req = 1'b0;
  logic          iwrite = 1'b0;
  logic [AW-1:0] iwrite_addr = '0;
  logic [DW-1:0] iwrite_data = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] i;
  logic          i_valid, busy, par_err;

  ucode_fetch dut (
    .clk(clk), .reset(reset), .pc(pc), .fetch_req(fetch_req),
    .iwrite(iwrite), .iwrite_addr(iwrite_addr), .iwrite_data(iwrite_data),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .i(i), .i_valid(i_valid), .busy(busy), .par_err(par_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [AW-1:0] a; logic [DW-1:0] d; } op_t;
  typedef struct { logic [DW-1:0] i; logic v; logic pe; } res_t;

  op_t  exp_ops[$];
  res_t exp_res[$];
  int   nchk = 0, nfail = 0;
  int   issued = 0, checked = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_odd(input logic [47:0] lo);
    return {~^lo, lo};
  endfunction

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return mk_odd({a, 20'hA5A5A, a});
  endfunction

  // Control memory seen by the responder, and the model's own view of it.
  logic [DW-1:0] cmem [logic [AW-1:0]];
  logic [DW-1:0] mmem [logic [AW-1:0]];

  function automatic logic [DW-1:0] cmem_rd(input logic [AW-1:0] a);
    return cmem.exists(a) ? cmem[a] : dflt(a);
  endfunction
  function automatic logic [DW-1:0] mmem_rd(input logic [AW-1:0] a);
    return mmem.exists(a) ? mmem[a] : dflt(a);
  endfunction

  // Memory responder and op monitor.
  bit  resp_en = 1'b1, man_ack = 1'b0, in_op = 1'b0;
  int  lat_force = -1, remain = 0, cycles = 0, last_cycles = 0;
  op_t cur, hd;

  initial forever begin
    @(negedge clk);
    if (!resp_en) begin
      mem_ack   = man_ack;
      mem_rdata = 49'h155;
    end else begin
      if (in_op && mem_ack) begin
        mem_ack = 1'b0;
        in_op = 1'b0;
        last_cycles = cycles;
        if (cur.wr) cmem[cur.a] = cur.d;
      end else if (in_op) begin
        cycles++;
        remain--;
        if (remain <= 0) begin
          mem_ack = 1'b1;
          if (!cur.wr) mem_rdata = cmem_rd(cur.a);
        end
      end
      if (!in_op && !reset && (mem_rd || mem_wr)) begin
        cur.wr = mem_wr; cur.a = mem_addr; cur.d = mem_wdata;
        in_op = 1'b1;
        cycles = 1;
        remain = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
        if (exp_ops.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL unexpected_op: got wr=%0b addr %0h expected no op", mem_wr, mem_addr);
        end else begin
          hd = exp_ops.pop_front();
          check("op_kind", 64'(mem_wr), 64'(hd.wr));
          check("op_addr", 64'(mem_addr), 64'(hd.a));
          if (hd.wr) check("op_wdata", 64'(mem_wdata), 64'(hd.d));
        end
        if (remain <= 0) begin
          mem_ack = 1'b1;
          if (!cur.wr) mem_rdata = cmem_rd(cur.a);
        end
      end
    end
  end

  // Result monitor: once a transaction has settled, compare IR state.
  res_t rh;
  initial forever begin
    @(negedge clk);
    if (!reset && issued > checked && !busy) begin
      checked++;
      if (exp_res.size() == 0) begin
        nchk++; nfail++;
        $display("FAIL unexpected_result: got i %0h expected none", i);
      end else begin
        rh = exp_res.pop_front();
        check("i", 64'(i), 64'(rh.i));
        check("i_valid", 64'(i_valid), 64'(rh.v));
        check("par_err", 64'(par_err), 64'(rh.pe));
      end
    end
  end

  // Transaction-level reference: one serialized request set issued in IDLE.
  logic          hv = 1'b0, mv = 1'b0, mpe = 1'b0;
  logic [AW-1:0] ha = '0;
  logic [DW-1:0] mi = '0;

  task automatic model_txn(input bit rd, input logic [AW-1:0] ra, input bit wr,
                           input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit push_res);
    op_t  op;
    res_t r;
    if (wr) begin
      op.wr = 1'b1; op.a = wa; op.d = wd;
      exp_ops.push_back(op);
      mmem[wa] = wd;
      if (hv && ha == wa) hv = 1'b0;
    end
    if (rd) begin
      if (!(hv && ha == ra)) begin
        op.wr = 1'b0; op.a = ra; op.d = '0;
        exp_ops.push_back(op);
        mi = mmem_rd(ra);
        ha = ra; hv = 1'b1;
        if (^mi == 1'b0) mpe = 1'b1;
      end
      mv = 1'b1;
    end
    if (push_res) begin
      r.i = mi; r.v = mv; r.pe = mpe;
      exp_res.push_back(r);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || checked != issued) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      nchk++; nfail++;
      $display("FAIL idle_timeout: got busy=%0b after %0d cycles expected idle", busy, n);
    end
  endtask

  task automatic settle();
    wait_idle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic txn(input bit rd, input logic [AW-1:0] ra, input bit wr,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    model_txn(rd, ra, wr, wa, wd, 1'b1);
    wait_idle();
    @(posedge clk); #1;
    fetch_req = rd; pc = ra; iwrite = wr; iwrite_addr = wa; iwrite_data = wd;
    @(posedge clk); #1;
    fetch_req = 1'b0; iwrite = 1'b0;
    issued++;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 14'h0100;
      1: return 14'h0200;
      2: return 14'h0300;
      3: return 14'h0400;
      4: return 14'h3FFF;
      default: return 14'h0000;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] d4;
  logic [AW-1:0] ha_keep;
  logic          hv_keep;
  logic [63:0]   rnd;
  int            kind;

  initial begin
    cmem[14'h0100] = 49'h0_0000_0000_0001;
    mmem[14'h0100] = 49'h0_0000_0000_0001;
    repeat (3) @(posedge clk);
    #1;
    check("rst_i", 64'(i), 64'h0);
    check("rst_i_valid", 64'(i_valid), 64'h0);
    check("rst_mem_rd", 64'(mem_rd), 64'h0);
    check("rst_mem_wr", 64'(mem_wr), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_par_err", 64'(par_err), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    reset = 1'b0;

    // Miss with three-cycle read strobe.
    lat_force = 2;
    txn(1'b1, 14'h0100, 1'b0, '0, '0);
    settle();
    check("rd_strobe_cycles", 64'(last_cycles), 64'd3);
    lat_force = -1;

    // Repeat fetch hits; simultaneous write+fetch at the hit address.
    txn(1'b1, 14'h0100, 1'b0, '0, '0);
    txn(1'b1, 14'h0100, 1'b1, 14'h0100, mk_odd(48'h1234_5678_9ABC));

    // Requests during RD_WAIT: last read wins, write goes first.
    d4 = mk_odd(48'hCAFE_0000_0404);
    model_txn(1'b1, 14'h0500, 1'b0, '0, '0, 1'b0);
    model_txn(1'b1, 14'h0300, 1'b1, 14'h0400, d4, 1'b1);
    wait_idle();
    lat_force = 6;
    @(posedge clk); #1; fetch_req = 1'b1; pc = 14'h0500;
    @(posedge clk); #1; pc = 14'h0200;
    @(posedge clk); #1; pc = 14'h0300;
    @(posedge clk); #1; fetch_req = 1'b0;
    iwrite = 1'b1; iwrite_addr = 14'h0400; iwrite_data = d4;
    @(posedge clk); #1; iwrite = 1'b0;
    lat_force = -1;
    issued++;

    // Randomized serialized traffic.
    for (int k = 0; k < 60; k++) begin
      kind = int'($urandom_range(0, 2));
      rnd = {$urandom, $urandom};
      txn(kind != 1, pick_addr(), kind != 0, pick_addr(), mk_odd(rnd[47:0]));
    end

    // Even-parity word sets sticky par_err.
    txn(1'b0, '0, 1'b1, 14'h0700, 49'h0);
    txn(1'b1, 14'h0700, 1'b0, '0, '0);
    txn(1'b1, 14'h0100, 1'b0, '0, '0);
    txn(1'b1, 14'h0200, 1'b0, '0, '0);

    // Reset while in RD_WAIT; a late ack must be ignored.
    settle();
    ha_keep = ha; hv_keep = hv;
    resp_en = 1'b0;
    @(posedge clk); #1; fetch_req = 1'b1; pc = 14'h0600;
    @(posedge clk); #1; fetch_req = 1'b0;
    @(negedge clk);
    check("abort_mem_rd", 64'(mem_rd), 64'h1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; man_ack = 1'b1;
    @(posedge clk); #1; man_ack = 1'b0;
    @(negedge clk);
    check("abort_mem_rd_low", 64'(mem_rd), 64'h0);
    check("abort_i", 64'(i), 64'h0);
    check("abort_i_valid", 64'(i_valid), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_par_err", 64'(par_err), 64'h0);
    @(negedge clk);
    resp_en = 1'b1;
    hv = 1'b0; mi = '0; mv = 1'b0; mpe = 1'b0;
    // Former hit address must now miss.
    txn(1'b1, hv_keep ? ha_keep : 14'h0100, 1'b0, '0, '0);
    txn(1'b1, 14'h0300, 1'b0, '0, '0);

    settle();
    check("ops_drained", 64'(exp_ops.size()), 64'd0);
    check("res_drained", 64'(exp_res.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
